// File: rtl/regmap_access_arbiter.sv
// regmap_access_arbiter: loads register defaults after reset, then round-robin arbitrates two requesters onto the register-map port.
module regmap_access_arbiter #(
  parameter int NUMREGS = 32,
  localparam int AW = $clog2(NUMREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUMREGS-1:0]   default_values,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [15:0]            req_addr,
  input  logic [15:0]            req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [7:0]             rsp_data,
  output logic [1:0]             addr_err,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [AW-1:0]          mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_next;
  logic [AW:0] idx;
  logic last, run, init_wr, hs, sel, we, inr, acc;
  logic [7:0] addr, wdata;
  logic s1_v, s1_port, s1_err, s2_err;
  always_ff @(posedge clk)
    if (reset) state <= INIT;
    else state <= state_next;
  always_comb begin
    run = state == RUN;
    init_wr = state == INIT && idx != (AW+1)'(NUMREGS);
    state_next = (state == INIT && !init_wr) ? RUN : state;
    // each ready sees only the valids and the last-grant pointer, never the other ready
    req_ready[0] = run & req_valid[0] & (~req_valid[1] | last);
    req_ready[1] = run & req_valid[1] & (~req_valid[0] | ~last);
    hs = |req_ready;
    sel = req_ready[1];
    addr = sel ? req_addr[15:8] : req_addr[7:0];
    wdata = sel ? req_wdata[15:8] : req_wdata[7:0];
    we = sel ? req_we[1] : req_we[0];
    inr = 32'(addr) < NUMREGS;
    acc = hs & inr;
    init_done = run;
    rsp_data = (|rsp_valid && !s2_err) ? mem_rdata : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      last <= 1'b1;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      addr_err <= 2'b00;
      s1_v <= 1'b0;
      s1_port <= 1'b0;
      s1_err <= 1'b0;
      rsp_valid <= 2'b00;
      s2_err <= 1'b0;
    end else begin
      mem_we <= init_wr | (acc & we);
      mem_re <= acc & ~we;
      if (init_wr) begin
        mem_addr <= idx[AW-1:0];
        mem_wdata <= default_values[{idx[AW-1:0], 3'b000} +: 8];
        idx <= idx + 1'b1;
      end else if (acc) begin
        mem_addr <= addr[AW-1:0];
        mem_wdata <= wdata;
      end
      if (hs) last <= sel;
      addr_err <= (hs && !inr) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      // out-of-range reads still flow down the pipe so they answer with zero at normal latency
      s1_v <= hs & ~we;
      s1_port <= sel;
      s1_err <= ~inr;
      rsp_valid <= s1_v ? (s1_port ? 2'b10 : 2'b01) : 2'b00;
      s2_err <= s1_err;
    end
  end
endmodule

// File: doc/regmap_access_arbiter.md
# regmap_access_arbiter

Sequences and shares the single access port of the 32-byte configuration register map. After reset it loads power-on defaults into every register. It then arbitrates read/write accesses between two requesters, the UART command path (port 0) and the on-chip calibration/trigger sequencer (port 1), with fair round-robin priority and a fixed read-response latency. It sits between the external interface and the register-map storage that drives the analog-core configuration bits.

## Interface
- NUMREGS, 32: number of 8-bit registers; the valid address range is 0..NUMREGS-1.
- clk  in  1  system/UART clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- default_values  in  8*NUMREGS  power-on value of register k in bits [8k+7:8k]; held static.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port request accepted this cycle (combinational).
- req_we  in  2  per-port request type: 1 = write, 0 = read.
- req_addr  in  2x8  per-port byte address.
- req_wdata  in  2x8  per-port write data.
- rsp_valid  out  2  one-cycle pulse: read data for that port is on rsp_data.
- rsp_data  out  8  read data, shared by both ports and qualified by rsp_valid.
- addr_err  out  2  one-cycle pulse: that port's accepted access was out of range.
- mem_we / mem_re  out  1 / 1  storage write / read strobes (registered).
- mem_addr  out  $clog2(NUMREGS)  storage address (registered).
- mem_wdata  out  8  storage write data (registered).
- mem_rdata  in  8  storage read data, valid the cycle after mem_re.
- init_done  out  1  high once the default load has completed.

## Operation
- States: INIT and RUN. Reset forces INIT with load index 0.
- INIT:
  - Each cycle: mem_we=1, mem_addr=index, mem_wdata=default_values slice for index; index increments.
  - After writing index NUMREGS-1, go to RUN.
  - req_ready=0 throughout INIT.
- RUN: init_done=1. Handshake completes on a port when req_valid&req_ready are high at a clock edge. At most one port is granted per cycle.
- Arbitration:
  - If only one port is valid, that port gets ready.
  - If both are valid, the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
  - The pointer updates only on a completed handshake.
- req_ready must not depend on the other port's ready. It is a function of state, both req_valid, and the pointer only.
- Accepted write, addr<NUMREGS: the next cycle has mem_we=1 with the address and data.
- Accepted read, addr<NUMREGS: the next cycle has mem_re=1. The following cycle has rsp_valid[port]=1 and rsp_data=mem_rdata.
- Out-of-range (addr>=NUMREGS):
  - No mem strobe.
  - addr_err[port] pulses in the cycle after acceptance.
  - A read also gets rsp_valid at the normal latency with rsp_data=0x00.
  - A write is silently dropped apart from the error pulse.
- Back-to-back accesses are permitted every cycle. The read pipeline is 2 deep, so responses return in acceptance order with no stall.
- rsp_data=0x00 whenever no rsp_valid is high.

## Timing
- Reset values: all outputs 0 and mem_addr=0. rsp_valid, addr_err, req_ready and init_done are low; pipeline is empty.
- INIT occupies the NUMREGS cycles after the first cycle with reset low (32 cycles by default). init_done rises, and req_ready can assert, on cycle NUMREGS+1.
- Write: handshake at edge E0; mem_we is high in cycle E0..E1.
- Read: handshake at E0, mem_re high in E0..E1, rsp_valid high in E1..E2. Latency is 2 cycles.
- Error pulse: cycle E0..E1.
- Reset mid-operation:
  - Pending reads are discarded, with no rsp_valid after reset.
  - In-flight mem strobes are cleared on the reset edge.
  - INIT restarts from index 0, even if a previous INIT was incomplete.
- Holding req_valid with changing addr/we/wdata before acceptance is legal. The values sampled at the handshake edge are the ones used.

## Test plan
- Reset release, default_values = register k holds k^0xA5 → 32 consecutive mem_we cycles, addr 0..31 with matching data → init_done=1 on cycle 33 → port 0 read of addr 7 returns 0xA2 two cycles after accept.
- Both ports hold valid for 6 cycles → grants alternate 0,1,0,1,0,1. Only one bit of req_ready is high per cycle; the pointer stays put during a cycle with no handshake.
- Port 1 writes 0x3C to addr 4, then port 0 reads addr 4 on the next cycle → rsp_valid[0] returns rsp_data=0x3C.
- Port 0 reads addr 40 → no mem_re, addr_err[0] pulse, rsp_valid[0] with 0x00 at 2-cycle latency. Port 1 writes to addr 255 → addr_err[1] pulse and no mem_we.
- Reads accepted on 3 consecutive cycles (ports 0,1,0) → three rsp_valid pulses on consecutive cycles, in order, with the correct data.
- Reset asserted for one cycle while a read is in flight → no rsp_valid, and a full INIT re-runs from addr 0.
